// File: rtl/reg_list_seq_if.sv
// ---------------------------------------------------------------------------
// reg_list_seq_if
// Handshake and data bundle between the instruction decode stage (master) and
// the register-list sequencer (slave).
//
// Signals
//   start      master->slave  load reg_list and begin a sequence
//   reg_list   master->slave  register list, bit n = register n
//   advance    master->slave  consumer accepts current reg_num (0 = stall)
//   abort      master->slave  flush the pending list, return to idle
//   busy       slave->master  sequence in progress
//   valid      slave->master  reg_num is meaningful
//   reg_num    slave->master  lowest pending register number
//   first      slave->master  reg_num is the first of the sequence
//   last       slave->master  exactly one register remains pending
//   done       slave->master  one-cycle pulse after the final transfer
//   remaining  slave->master  popcount of pending (only with REGSEQ_COUNT_EN)
//
// Configuration macro: REGSEQ_COUNT_EN adds the 'remaining' count.
// ---------------------------------------------------------------------------
interface reg_list_seq_if #(
   parameter int LIST_W = 16,
   parameter int NUM_W  = 4
);

   logic              start;
   logic [LIST_W-1:0] reg_list;
   logic              advance;
   logic              abort;
   logic              busy;
   logic              valid;
   logic [NUM_W-1:0]  reg_num;
   logic              first;
   logic              last;
   logic              done;
`ifdef REGSEQ_COUNT_EN
   logic [NUM_W:0]    remaining;
`endif

`ifdef REGSEQ_COUNT_EN
   modport master (
      output start, reg_list, advance, abort,
      input  busy, valid, reg_num, first, last, done, remaining
   );

   modport slave (
      input  start, reg_list, advance, abort,
      output busy, valid, reg_num, first, last, done, remaining
   );
`else
   modport master (
      output start, reg_list, advance, abort,
      input  busy, valid, reg_num, first, last, done
   );

   modport slave (
      input  start, reg_list, advance, abort,
      output busy, valid, reg_num, first, last, done
   );
`endif

endinterface

// File: rtl/reg_list_seq.sv
// ---------------------------------------------------------------------------
// reg_list_seq
// Walks a 16-bit LDM/STM register list and emits one register number per
// accepted transfer, lowest register first. The inverse of the 4->16 register
// decoder; it sequences multi-register transfers under pipeline stalls.
//
// Ports
//   clk      core clock, rising edge
//   nRESET   asynchronous active-low reset
//   bus      reg_list_seq_if.slave: start/reg_list/advance/abort in,
//            busy/valid/reg_num/first/last/done (and remaining) out
//
// Configuration macro: REGSEQ_COUNT_EN adds bus.remaining = popcount(pending).
// ---------------------------------------------------------------------------
module reg_list_seq #(
   parameter int LIST_W = 16,
   parameter int NUM_W  = 4
) (
   input  logic          clk,
   input  logic          nRESET,
   reg_list_seq_if.slave bus
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t            r_state;
   logic [LIST_W-1:0] r_pending;
   logic              r_first;
   logic              r_done;

   state_t            w_stateNext;
   logic [LIST_W-1:0] w_pendingNext;
   logic              w_firstNext;
   logic              w_doneNext;
   logic [NUM_W-1:0]  w_regNum;
   logic [LIST_W-1:0] w_regOnehot;
   logic              w_last;

   // Lowest set bit wins: scanning downward lets each lower bit overwrite.
   always_comb begin
      w_regNum = '0;
      for (int i = LIST_W - 1; i >= 0; i--) begin
         if (r_pending[i]) begin
            w_regNum = NUM_W'(i);
         end
      end
   end

   assign w_regOnehot = LIST_W'(1) << w_regNum;
   assign w_last      = $onehot(r_pending);

   // State register; pending list, first flag and done pulse move with it.
   always_ff @(posedge clk or negedge nRESET) begin
      if (!nRESET) begin
         r_state   <= IDLE;
         r_pending <= '0;
         r_first   <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_stateNext;
         r_pending <= w_pendingNext;
         r_first   <= w_firstNext;
         r_done    <= w_doneNext;
      end
   end

   // Abort overrides everything, including a start in idle. An empty list
   // never enters RUN but still reports done so the decoder can move on.
   always_comb begin
      w_stateNext   = r_state;
      w_pendingNext = r_pending;
      w_firstNext   = r_first;
      w_doneNext    = 1'b0;
      if (bus.abort) begin
         w_stateNext   = IDLE;
         w_pendingNext = '0;
         w_firstNext   = 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  if (bus.reg_list != '0) begin
                     w_stateNext   = RUN;
                     w_pendingNext = bus.reg_list;
                     w_firstNext   = 1'b1;
                  end else begin
                     w_doneNext = 1'b1;
                  end
               end
            end
            RUN: begin
               if (bus.advance) begin
                  w_firstNext = 1'b0;
                  if (w_last) begin
                     w_stateNext   = IDLE;
                     w_pendingNext = '0;
                     w_doneNext    = 1'b1;
                  end else begin
                     w_pendingNext = r_pending & ~w_regOnehot;
                  end
               end
            end
            default: begin
               w_stateNext   = IDLE;
               w_pendingNext = '0;
               w_firstNext   = 1'b0;
            end
         endcase
      end
   end

   // Outputs derive from registered state only, so a stalled consumer sees
   // stable values. Pending is zero in idle, which forces reg_num and last low.
   always_comb begin
      bus.busy    = (r_state == RUN);
      bus.valid   = (r_state == RUN);
      bus.reg_num = w_regNum;
      bus.first   = r_first;
      bus.last    = w_last;
      bus.done    = r_done;
   end

`ifdef REGSEQ_COUNT_EN
   logic [NUM_W:0] w_count;

   // Remaining transfers, used for decrement-mode base address computation.
   always_comb begin
      w_count = '0;
      for (int i = 0; i < LIST_W; i++) begin
         w_count = w_count + (NUM_W + 1)'(r_pending[i]);
      end
   end

   assign bus.remaining = w_count;
`endif

endmodule

// File: tb/tb_reg_list_seq.sv
// ---------------------------------------------------------------------------
// tb_reg_list_seq
// Directed bench for reg_list_seq. A queue-based model holds the pending
// register numbers in ascending order; a compare process checks every DUT
// output against it on each falling clock edge. Hand-computed literal checks
// in the stimulus flow pin the model itself.
// ---------------------------------------------------------------------------
module tb_reg_list_seq;

   logic clk;
   logic nRESET;

   int vecCount;
   int errCount;

   reg_list_seq_if #(.LIST_W(16), .NUM_W(4)) bus ();

   reg_list_seq #(.LIST_W(16), .NUM_W(4)) dut (
      .clk    (clk),
      .nRESET (nRESET),
      .bus    (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Model: queue of register numbers still to transfer, plus first/done flags.
   int mdlQ[$];
   bit mdlFirst;
   bit mdlDone;

   always @(posedge clk or negedge nRESET) begin
      if (!nRESET) begin
         mdlQ.delete();
         mdlFirst = 1'b0;
         mdlDone  = 1'b0;
      end else begin
         mdlDone = 1'b0;
         if (bus.abort) begin
            mdlQ.delete();
            mdlFirst = 1'b0;
         end else if (mdlQ.size() == 0) begin
            if (bus.start) begin
               for (int n = 0; n < 16; n++) begin
                  if (bus.reg_list[n]) mdlQ.push_back(n);
               end
               if (mdlQ.size() == 0) mdlDone = 1'b1;
               else mdlFirst = 1'b1;
            end
         end else if (bus.advance) begin
            void'(mdlQ.pop_front());
            mdlFirst = 1'b0;
            if (mdlQ.size() == 0) mdlDone = 1'b1;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      vecCount++;
      if (act !== exp) begin
         errCount++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare process: every falling edge, all outputs against the model.
   always @(negedge clk) begin
      int expNum;
      expNum = (mdlQ.size() != 0) ? mdlQ[0] : 0;
      checkOutput("busy",    32'(bus.busy),    32'(mdlQ.size() != 0));
      checkOutput("valid",   32'(bus.valid),   32'(mdlQ.size() != 0));
      checkOutput("reg_num", 32'(bus.reg_num), 32'(expNum));
      checkOutput("first",   32'(bus.first),   32'(mdlFirst));
      checkOutput("last",    32'(bus.last),    32'(mdlQ.size() == 1));
      checkOutput("done",    32'(bus.done),    32'(mdlDone));
`ifdef REGSEQ_COUNT_EN
      checkOutput("remaining", 32'(bus.remaining), 32'(mdlQ.size()));
`endif
   end

   // Drive inputs at the falling edge, return 1 time unit after the next rise.
   task automatic applyStimulus(input logic st, input logic [15:0] lst,
                                input logic adv, input logic ab);
      @(negedge clk);
      bus.start    = st;
      bus.reg_list = lst;
      bus.advance  = adv;
      bus.abort    = ab;
      @(posedge clk);
      #1;
   endtask

   initial begin
      vecCount     = 0;
      errCount     = 0;
      nRESET       = 1'b0;
      bus.start    = 1'b0;
      bus.reg_list = '0;
      bus.advance  = 1'b0;
      bus.abort    = 1'b0;
      #3;
      checkOutput("rst_busy",    32'(bus.busy),    32'd0);
      checkOutput("rst_reg_num", 32'(bus.reg_num), 32'd0);
      checkOutput("rst_done",    32'(bus.done),    32'd0);
      repeat (2) @(negedge clk);
      nRESET = 1'b1;

      // 1: 0x8421 with advance held high -> 0,5,10,15 then done.
      applyStimulus(1'b1, 16'h8421, 1'b1, 1'b0);
      checkOutput("t1_num0",   32'(bus.reg_num), 32'd0);
      checkOutput("t1_first0", 32'(bus.first),   32'd1);
      applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
      checkOutput("t1_num1",   32'(bus.reg_num), 32'd5);
      checkOutput("t1_first1", 32'(bus.first),   32'd0);
      applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
      checkOutput("t1_num2",   32'(bus.reg_num), 32'd10);
      applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
      checkOutput("t1_num3",   32'(bus.reg_num), 32'd15);
      checkOutput("t1_last3",  32'(bus.last),    32'd1);
      applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
      checkOutput("t1_done",   32'(bus.done),    32'd1);
      checkOutput("t1_busy",   32'(bus.busy),    32'd0);
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
      checkOutput("t1_done_off", 32'(bus.done),  32'd0);

      // 2: 0x0006 with a three-cycle stall.
      applyStimulus(1'b1, 16'h0006, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
      checkOutput("t2_held_num",   32'(bus.reg_num), 32'd1);
      checkOutput("t2_held_first", 32'(bus.first),   32'd1);
      applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
      checkOutput("t2_num2",  32'(bus.reg_num), 32'd2);
      checkOutput("t2_last",  32'(bus.last),    32'd1);
      applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
      checkOutput("t2_done",  32'(bus.done),    32'd1);

      // 3: empty list -> done only.
      applyStimulus(1'b1, 16'h0000, 1'b1, 1'b0);
      checkOutput("t3_busy",  32'(bus.valid),   32'd0);
      checkOutput("t3_done",  32'(bus.done),    32'd1);
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);

      // 4: abort at register 7, then start+abort in idle is dropped.
      applyStimulus(1'b1, 16'hFFFF, 1'b1, 1'b0);
      for (int k = 0; k < 7; k++) applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
      checkOutput("t4_num7",  32'(bus.reg_num), 32'd7);
      applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1);
      checkOutput("t4_abort_busy", 32'(bus.busy), 32'd0);
      checkOutput("t4_abort_done", 32'(bus.done), 32'd0);
      applyStimulus(1'b1, 16'hFFFF, 1'b1, 1'b1);
      checkOutput("t4_drop_busy",  32'(bus.busy), 32'd0);
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);

      // 5: start while busy is ignored; start in the done cycle is accepted.
      applyStimulus(1'b1, 16'h0003, 1'b1, 1'b0);
      applyStimulus(1'b1, 16'h0010, 1'b1, 1'b0);
      checkOutput("t5_num1",  32'(bus.reg_num), 32'd1);
      applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
      checkOutput("t5_done",  32'(bus.done),    32'd1);
      applyStimulus(1'b1, 16'h0010, 1'b1, 1'b0);
      checkOutput("t5_num4",  32'(bus.reg_num), 32'd4);
      checkOutput("t5_first", 32'(bus.first),   32'd1);
      checkOutput("t5_last",  32'(bus.last),    32'd1);
      applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);

      // 6: asynchronous reset between edges, then a full list.
      applyStimulus(1'b1, 16'hFFFF, 1'b1, 1'b0);
      for (int k = 0; k < 3; k++) applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
      #2;
      nRESET = 1'b0;
      #1;
      checkOutput("t6_rst_busy",  32'(bus.busy),    32'd0);
      checkOutput("t6_rst_num",   32'(bus.reg_num), 32'd0);
      checkOutput("t6_rst_first", 32'(bus.first),   32'd0);
      checkOutput("t6_rst_last",  32'(bus.last),    32'd0);
      @(negedge clk);
      bus.start   = 1'b0;
      bus.advance = 1'b0;
      @(negedge clk);
      nRESET = 1'b1;
      checkOutput("t6_no_done", 32'(bus.done), 32'd0);
      applyStimulus(1'b1, 16'hFFFF, 1'b1, 1'b0);
      for (int k = 0; k < 16; k++) begin
         checkOutput("t6_seq_num", 32'(bus.reg_num), 32'(k));
`ifdef REGSEQ_COUNT_EN
         checkOutput("t6_remaining", 32'(bus.remaining), 32'(16 - k));
`endif
         applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
      end
      checkOutput("t6_done", 32'(bus.done), 32'd1);
`ifdef REGSEQ_COUNT_EN
      checkOutput("t6_remaining_end", 32'(bus.remaining), 32'd0);
`endif
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
      $finish;
   end

endmodule
